// File: rtl/scroll_ctrl.sv
// Scrolls a two-character window across a stored message for a 2-digit 7-seg driver.
// Build option: define SCROLL_LOOP_EN for continuous (wrapping) scrolling instead of one-shot.
module scroll_ctrl #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned STEP_W = 24
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [5:0]               wr_data,
    input  logic                     clr,
    input  logic                     start,
    input  logic                     stop,
    output logic [5:0]               data1,
    output logic [5:0]               data2,
    output logic [$clog2(DEPTH):0]   len,
    output logic                     full,
    output logic                     busy,
    output logic                     done
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = PW + 1;

    typedef enum logic [0:0] {
        StIdle,
        StScroll
    } state_e;

    state_e              state_q, state_d;
    logic [LW-1:0]       len_q, len_d;
    logic [PW-1:0]       pos_q, pos_d;
    logic [STEP_W-1:0]   div_q, div_d;
    logic [5:0]          data1_q, data1_d;
    logic [5:0]          data2_q, data2_d;
    logic                full_q, full_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [5:0]          buf_q [DEPTH];
    logic                buf_we;
    logic [PW-1:0]       buf_waddr;

    logic                step;
    logic [LW-1:0]       pos_inc;

`ifdef SCROLL_LOOP_EN
    logic [PW-1:0]       nxt;
    logic [LW-1:0]       nxt_inc;
    logic [PW-1:0]       nxt2;

    // Window indices wrap modulo the message length, which need not be a power of 2.
    always_comb begin
        nxt     = (pos_inc == len_q) ? '0 : pos_inc[PW-1:0];
        nxt_inc = {1'b0, nxt} + LW'(1);
        nxt2    = (nxt_inc == len_q) ? '0 : nxt_inc[PW-1:0];
    end
`else
    logic [LW-1:0]       len_m2;
    logic [PW-1:0]       pos_p2;

    always_comb begin
        len_m2 = len_q - LW'(2);
        pos_p2 = pos_q + PW'(2);
    end
`endif

    always_comb begin
        step    = (div_q == {STEP_W{1'b1}});
        pos_inc = {1'b0, pos_q} + LW'(1);
    end

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        pos_d     = pos_q;
        div_d     = '0;
        data1_d   = data1_q;
        data2_d   = data2_q;
        done_d    = 1'b0;
        buf_we    = 1'b0;
        buf_waddr = len_q[PW-1:0];

        if (clr) begin
            state_d = StIdle;
            len_d   = '0;
            pos_d   = '0;
            data1_d = '0;
            data2_d = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start && (len_q >= LW'(2))) begin
                        state_d = StScroll;
                        pos_d   = '0;
                        data1_d = buf_q[0];
                        data2_d = buf_q[1];
                    end else if (wr_en && !full_q) begin
                        buf_we = 1'b1;
                        len_d  = len_q + LW'(1);
                    end
                end
                StScroll: begin
                    if (stop) begin
                        state_d = StIdle;
                        pos_d   = '0;
                    end else begin
                        div_d = div_q + STEP_W'(1);
                        if (step) begin
`ifdef SCROLL_LOOP_EN
                            pos_d   = nxt;
                            data1_d = buf_q[nxt];
                            data2_d = buf_q[nxt2];
`else
                            if ({1'b0, pos_q} < len_m2) begin
                                pos_d   = pos_inc[PW-1:0];
                                data1_d = buf_q[pos_inc[PW-1:0]];
                                data2_d = buf_q[pos_p2];
                            end else begin
                                // Last window stays on the display after completion.
                                state_d = StIdle;
                                pos_d   = '0;
                                done_d  = 1'b1;
                            end
`endif
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        full_d = (len_d == LW'(DEPTH));
        busy_d = (state_d == StScroll);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            len_q   <= '0;
            pos_q   <= '0;
            div_q   <= '0;
            data1_q <= '0;
            data2_q <= '0;
            full_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            pos_q   <= pos_d;
            div_q   <= div_d;
            data1_q <= data1_d;
            data2_q <= data2_d;
            full_q  <= full_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Message storage needs no reset; only entries below len are ever read.
    always_ff @(posedge clk) begin
        if (buf_we) begin
            buf_q[buf_waddr] <= wr_data;
        end
    end

    assign data1 = data1_q;
    assign data2 = data2_q;
    assign len   = len_q;
    assign full  = full_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_scroll_ctrl.sv
// Directed self-checking bench for scroll_ctrl (DEPTH=16, STEP_W=2).
module tb_scroll_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [5:0] wr_data = '0;
    logic       clr = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [5:0] data1, data2;
    logic [4:0] len;
    logic       full, busy, done;

    int total = 0;
    int bad = 0;

    logic [5:0] tbl1 [4] = '{6'd10, 6'd11, 6'd12, 6'd10};
    logic [5:0] tbl2 [4] = '{6'd11, 6'd12, 6'd10, 6'd11};

    scroll_ctrl #(.DEPTH(16), .STEP_W(2)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .clr(clr),
        .start(start), .stop(stop), .data1(data1), .data2(data2), .len(len),
        .full(full), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic write_char(input logic [5:0] c);
        wr_en = 1'b1; wr_data = c;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic clear_msg();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        total++;
        if ({data1, data2, len, busy, full, done} !== 20'd0) begin
            bad++;
            $display("FAIL reset_hold: got d1=%0d d2=%0d len=%0d busy=%b full=%b done=%b want all 0",
                     data1, data2, len, busy, full, done);
        end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if ({data1, data2, len, busy, full, done} !== 20'd0) begin
            bad++;
            $display("FAIL reset_release: got d1=%0d d2=%0d len=%0d busy=%b full=%b done=%b want 0",
                     data1, data2, len, busy, full, done);
        end
    endtask

    task automatic test_scroll();
        logic [5:0] e1, e2;
        logic       eb, ed;
        clear_msg();
        write_char(6'd10); write_char(6'd11); write_char(6'd12);
        total++;
        if (len !== 5'd3) begin
            bad++; $display("FAIL scroll_len: got %0d want 3", len);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 14; k++) begin
`ifdef SCROLL_LOOP_EN
            e1 = tbl1[k/4]; e2 = tbl2[k/4]; eb = 1'b1; ed = 1'b0;
`else
            e1 = (k < 4) ? 6'd10 : 6'd11;
            e2 = (k < 4) ? 6'd11 : 6'd12;
            eb = (k < 8);
            ed = (k == 8);
`endif
            total++;
            if ({data1, data2, busy, done} !== {e1, e2, eb, ed}) begin
                bad++;
                $display("FAIL scroll_cycle%0d: got %0d/%0d busy=%b done=%b want %0d/%0d busy=%b done=%b",
                         k, data1, data2, busy, done, e1, e2, eb, ed);
            end
            @(negedge clk);
        end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
`ifdef SCROLL_LOOP_EN
        e1 = 6'd10; e2 = 6'd11;
`else
        e1 = 6'd11; e2 = 6'd12;
`endif
        total++;
        if ({data1, data2, busy, done} !== {e1, e2, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL scroll_stop: got %0d/%0d busy=%b done=%b want %0d/%0d busy=0 done=0",
                     data1, data2, busy, done, e1, e2);
        end
    endtask

    task automatic test_capacity();
        clear_msg();
        for (int i = 0; i < 17; i++) begin
            write_char(6'(i));
            if (i == 14) begin
                total++;
                if (full !== 1'b0 || len !== 5'd15) begin
                    bad++; $display("FAIL cap_15: got full=%b len=%0d want 0/15", full, len);
                end
            end
            if (i == 15) begin
                total++;
                if (full !== 1'b1 || len !== 5'd16) begin
                    bad++; $display("FAIL cap_16: got full=%b len=%0d want 1/16", full, len);
                end
            end
        end
        total++;
        if (full !== 1'b1 || len !== 5'd16) begin
            bad++; $display("FAIL cap_17: got full=%b len=%0d want 1/16", full, len);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        write_char(6'd33);
        total++;
        if (len !== 5'd16 || busy !== 1'b1 || data1 !== 6'd0 || data2 !== 6'd1) begin
            bad++;
            $display("FAIL cap_scroll_write: got len=%0d busy=%b %0d/%0d want 16 1 0/1",
                     len, busy, data1, data2);
        end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
    endtask

    task automatic test_guards();
        clear_msg();
        write_char(6'd5);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        total++;
        if (busy !== 1'b0 || len !== 5'd1 || data1 !== 6'd0 || data2 !== 6'd0) begin
            bad++;
            $display("FAIL guard_short: got busy=%b len=%0d %0d/%0d want 0 1 0/0",
                     busy, len, data1, data2);
        end
        write_char(6'd6); write_char(6'd7);
        start = 1'b1; wr_en = 1'b1; wr_data = 6'd9;
        @(negedge clk);
        start = 1'b0; wr_en = 1'b0;
        total++;
        if (busy !== 1'b1 || len !== 5'd3 || data1 !== 6'd5 || data2 !== 6'd6) begin
            bad++;
            $display("FAIL guard_start_wr: got busy=%b len=%0d %0d/%0d want 1 3 5/6",
                     busy, len, data1, data2);
        end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        clr = 1'b1; start = 1'b1;
        @(negedge clk);
        clr = 1'b0; start = 1'b0;
        total++;
        if ({len, busy, data1, data2, full} !== 19'd0) begin
            bad++;
            $display("FAIL guard_clr_start: got len=%0d busy=%b %0d/%0d full=%b want 0 0 0/0 0",
                     len, busy, data1, data2, full);
        end
    endtask

    task automatic test_abort();
        write_char(6'd1); write_char(6'd2); write_char(6'd3);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        total++;
        if (data1 !== 6'd2 || data2 !== 6'd3 || busy !== 1'b1) begin
            bad++;
            $display("FAIL abort_pre: got %0d/%0d busy=%b want 2/3 busy=1", data1, data2, busy);
        end
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        total++;
        if ({len, busy, data1, data2, done} !== 18'd0) begin
            bad++;
            $display("FAIL abort_clr: got len=%0d busy=%b %0d/%0d done=%b want all 0",
                     len, busy, data1, data2, done);
        end
        repeat (4) begin
            @(negedge clk);
            total++;
            if (done !== 1'b0) begin
                bad++; $display("FAIL abort_nodone: got done=%b want 0", done);
            end
        end
        write_char(6'd1); write_char(6'd2); write_char(6'd3);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++;
        if ({data1, data2, len, busy, full, done} !== 20'd0) begin
            bad++;
            $display("FAIL abort_rst: got d1=%0d d2=%0d len=%0d busy=%b full=%b done=%b want 0",
                     data1, data2, len, busy, full, done);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_scroll();
        test_capacity();
        test_guards();
        test_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/scroll_ctrl.md
Name: scroll_ctrl

Overview:
- Sequences a character message onto the two-digit 7-seg display driver: its data1/data2 outputs feed that driver's 6-bit character inputs (codes 0-35 = 0-9, A-Z).
- Holds a message of up to DEPTH characters, loaded through a simple write port.
- Scrolls a two-character window across the message at a fixed step rate, one-shot or looping.
- Reports busy/done status to the top-level control logic.

Parameters:
- DEPTH, 16: maximum message length in characters; must be a power of 2, ≥2.
- STEP_W, 24: width of the step-divider counter; window advances every 2^STEP_W clocks.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- wr_en  in  1  write strobe: append wr_data to the message.
- wr_data  in  6  character code to append (0-35).
- clr  in  1  clear the message and abort any scroll.
- start  in  1  begin scrolling (IDLE only).
- stop  in  1  abort scrolling (SCROLL only).
- data1  out  6  left-digit character code to the display driver.
- data2  out  6  right-digit character code to the display driver.
- len  out  $clog2(DEPTH)+1  number of characters currently stored.
- full  out  1  high when len == DEPTH.
- busy  out  1  high while in SCROLL.
- done  out  1  one-cycle pulse when a one-shot scroll completes.

Behaviour:
- Reset (async, rst=1):
  - state = IDLE; len = 0; pos = 0; divider = 0.
  - data1 = data2 = 0; busy = full = done = 0.
  - Buffer contents are don't-care.
- All outputs are registered. done is zero except for its single pulse cycle.
- States: IDLE, SCROLL.
- Command priority each cycle: clr > stop > start > wr_en.
- clr (any state), next cycle:
  - len = 0, state = IDLE, busy = 0, data1 = data2 = 0.
  - No done pulse.
- wr_en in IDLE with len < DEPTH: buf[len] <= wr_data; len increments by 1.
- wr_en is ignored (no write, len unchanged) when:
  - the buffer is full;
  - the state is SCROLL;
  - the same cycle carries an accepted start, clr or stop.
- full is updated in the same cycle len updates.
- start in IDLE with len >= 2, next cycle:
  - state = SCROLL, busy = 1, pos = 0, divider = 0.
  - data1 = buf[0], data2 = buf[1].
- start in IDLE with len < 2: ignored, no state change. start in SCROLL: ignored.
- SCROLL divider and step:
  - The divider increments every clock.
  - A step occurs on the cycle the divider equals 2^STEP_W-1; the divider then wraps to 0.
  - The first step therefore occurs 2^STEP_W clocks after the window first appears.
- Step handling, one-shot (LOOP_EN undefined):
  - If pos < len-2: pos = pos+1; next cycle data1 = buf[pos], data2 = buf[pos+1].
  - If pos == len-2: state = IDLE, busy = 0, done = 1 for one cycle; data1/data2 hold the last window.
- stop in SCROLL, next cycle:
  - state = IDLE, busy = 0; data1/data2 hold their current values.
  - No done pulse; divider and pos reset to 0.
- In IDLE, data1/data2 hold their last value. They change only on clr, start, step or reset.
- len is stable during SCROLL; writes are blocked there.
- Reset asserted mid-scroll returns every output to its reset value immediately (asynchronous).

Optional Feature:
- Macro: SCROLL_LOOP_EN.
- Defined: scrolling is continuous.
  - Window indices wrap modulo len: data2 = buf[(pos+1) mod len].
  - pos advances 0..len-1, then back to 0.
  - done never pulses; SCROLL exits only via stop, clr or rst.
- Undefined: one-shot behaviour as described in Behaviour.

Test Plan:
- Reset: assert rst mid-cycle -> data1 = data2 = 0, len = 0, busy = full = done = 0 with no clock edge required.
- One-shot (STEP_W=2, no macro):
  - Stimulus: write 10, 11, 12 (A, b, C), then pulse start.
  - Next cycle: data1/data2 = 10/11, busy = 1.
  - 4 clocks later: 11/12.
  - 4 clocks after that: done pulses once, busy = 0, outputs hold 11/12.
- Loop (STEP_W=2, SCROLL_LOOP_EN defined):
  - Stimulus: same 3 characters, then start.
  - Windows every 4 clocks: 10/11, 11/12, 12/10, 10/11, ...
  - done is never asserted; stop -> busy = 0 next cycle, window held.
- Capacity (DEPTH=16):
  - Write 17 characters 0..16 in IDLE.
  - full asserts after the 16th; the 17th is dropped; len = 16.
  - A wr_en issued during SCROLL leaves len = 16.
- Guards and priority:
  - start with len = 1 -> no change, busy stays 0.
  - clr + start in the same cycle -> len = 0, IDLE, outputs 0.
  - wr_en + accepted start in the same cycle -> write dropped, len unchanged.
- Abort:
  - clr mid-scroll -> next cycle IDLE, len = 0, data1 = data2 = 0, no done pulse.
  - rst mid-scroll -> all reset values.
